// File: rtl/calc2_port_sched.sv
// Tags requests, issues each to a calc2 port as a cmd/op1 beat followed by an op2 beat,
// and returns responses in arrival order through a 4-entry FIFO with per-tag timeout.
module calc2_port_sched #(
   parameter int TIMEOUT = 255
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_cmd,
   input  logic [31:0] req_op1,
   input  logic [31:0] req_op2,
   output logic [1:0]  req_tag,
   output logic [3:0]  port_cmd,
   output logic [31:0] port_data,
   output logic [1:0]  port_tag,
   input  logic [1:0]  port_resp,
   input  logic [31:0] port_rdata,
   input  logic [1:0]  port_rtag,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [1:0]  rsp_resp,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_tag,
   output logic [2:0]  outstanding,
   output logic        err_spurious,
   output logic        err_timeout
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE1, S_ISSUE2} state_t;
   typedef enum logic [1:0] {T_FREE, T_WAIT, T_DONE} tag_st_t;

   // A WAIT tag retires on the edge where its timer would reach TIMEOUT.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      r_state, w_state_nxt;
   tag_st_t     r_tag_st [4];
   tag_st_t     w_tag_nxt [4];
   logic [7:0]  r_timer [4];
   logic [7:0]  w_timer_nxt [4];
   logic [3:0]  w_to;
   logic        w_any_free, w_accept, w_push, w_spur, w_pop;
   logic [1:0]  w_alloc, w_head_tag;
   logic [3:0]  r_cmd;
   logic [31:0] r_op1, r_op2;
   logic [1:0]  r_tag;
   logic [35:0] r_fifo [4];
   logic [35:0] w_head;
   logic [1:0]  r_wr, r_rd;
   logic [2:0]  r_cnt, r_outstanding, w_busy_nxt;
   logic        r_err_spur, r_err_to;

   // Lowest-numbered FREE tag, taken from registered state only.
   always_comb begin
      w_any_free = 1'b0;
      w_alloc    = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (r_tag_st[i] == T_FREE) begin
            w_any_free = 1'b1;
            w_alloc    = 2'(i);
         end
      end
   end

   assign req_ready = reset & w_any_free & (r_state != S_ISSUE1);
   assign req_tag   = w_alloc;
   assign w_accept  = req_valid & req_ready;

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = S_ISSUE1;
         S_ISSUE1: w_state_nxt = S_ISSUE2;
         S_ISSUE2: w_state_nxt = w_accept ? S_ISSUE1 : S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      port_cmd  = '0;
      port_data = '0;
      case (r_state)
         S_ISSUE1: begin
            port_cmd  = r_cmd;
            port_data = r_op1;
         end
         S_ISSUE2: port_data = r_op2;
         default: ;
      endcase
   end

   assign port_tag = r_tag;

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         r_cmd <= '0;
         r_op1 <= '0;
         r_op2 <= '0;
         r_tag <= '0;
      end else if (w_accept) begin
         r_cmd <= req_cmd;
         r_op1 <= req_op1;
         r_op2 <= req_op2;
         r_tag <= w_alloc;
      end
   end

   assign w_push = (port_resp != 2'd0) && (r_tag_st[port_rtag] == T_WAIT);
   assign w_spur = (port_resp != 2'd0) && !w_push;
   assign w_pop  = rsp_valid & rsp_ready;

   // Per-tag lifecycle; a response beats a timeout landing on the same edge.
   always_comb begin
      w_busy_nxt = '0;
      w_to       = '0;
      for (int i = 0; i < 4; i++) begin
         w_tag_nxt[i]   = r_tag_st[i];
         w_timer_nxt[i] = r_timer[i];
         case (r_tag_st[i])
            T_FREE: if (w_accept && w_alloc == 2'(i)) begin
               w_tag_nxt[i]   = T_WAIT;
               w_timer_nxt[i] = '0;
            end
            T_WAIT: begin
               w_timer_nxt[i] = r_timer[i] + 8'd1;
               if (w_push && port_rtag == 2'(i)) begin
                  w_tag_nxt[i] = T_DONE;
               end else if (r_timer[i] == TO_LAST) begin
                  w_tag_nxt[i] = T_FREE;
                  w_to[i]      = 1'b1;
               end
            end
            T_DONE: if (w_pop && w_head_tag == 2'(i)) w_tag_nxt[i] = T_FREE;
            default: w_tag_nxt[i] = T_FREE;
         endcase
         if (w_tag_nxt[i] != T_FREE) w_busy_nxt = w_busy_nxt + 3'd1;
      end
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) begin
            r_tag_st[i] <= T_FREE;
            r_timer[i]  <= '0;
         end
         r_outstanding <= '0;
         r_err_spur    <= 1'b0;
         r_err_to      <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            r_tag_st[i] <= w_tag_nxt[i];
            r_timer[i]  <= w_timer_nxt[i];
         end
         r_outstanding <= w_busy_nxt;
         r_err_spur    <= r_err_spur | w_spur;
         r_err_to      <= r_err_to | (|w_to);
      end
   end

   assign outstanding  = r_outstanding;
   assign err_spurious = r_err_spur;
   assign err_timeout  = r_err_to;

   // Occupancy is bounded by the four tags, so no full check is needed.
   always_ff @(posedge c_clk) begin
      if (w_push) r_fifo[r_wr] <= {port_resp, port_rdata, port_rtag};
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 2'd1;
         if (w_pop)  r_rd <= r_rd + 2'd1;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 3'd1;
            2'b01:   r_cnt <= r_cnt - 3'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   assign w_head     = r_fifo[r_rd];
   assign w_head_tag = w_head[1:0];
   assign rsp_valid  = (r_cnt != 3'd0);
   assign rsp_resp   = rsp_valid ? w_head[35:34] : '0;
   assign rsp_data   = rsp_valid ? w_head[33:2]  : '0;
   assign rsp_tag    = rsp_valid ? w_head[1:0]   : '0;

endmodule
